// File: rtl/collider_if.sv
// Collider bus: the player position and tile-map write port going in,
// and the four registered free-space limits coming back out.
interface collider_if;
  logic signed [31:0] player_X_Pos;
  logic signed [31:0] player_Y_Pos;
  logic               map_we;
  logic [4:0]         map_row;
  logic [5:0]         map_col;
  logic               map_solid;
  logic signed [31:0] player_X_Min;
  logic signed [31:0] player_X_Max;
  logic signed [31:0] player_Y_Min;
  logic signed [31:0] player_Y_Max;

  // Player controller side: drives position and map edits, reads limits.
  modport master (
    output player_X_Pos, player_Y_Pos, map_we, map_row, map_col, map_solid,
    input  player_X_Min, player_X_Max, player_Y_Min, player_Y_Max
  );

  // Collider side.
  modport slave (
    input  player_X_Pos, player_Y_Pos, map_we, map_row, map_col, map_solid,
    output player_X_Min, player_X_Max, player_Y_Min, player_Y_Max
  );
endinterface

// File: rtl/collider.sv
// Per-player collision-boundary generator. Keeps a solid/empty tile map
// of the 640x480 playfield and, each clock, registers the nearest free-space
// limits around the player hitbox. Tiles overlapping the hitbox are ignored.
module collider #(
  parameter int PLAYER_W     = 32,
  parameter int PLAYER_H     = 48,
  parameter int TILE         = 16,
  parameter int MAP_COLS     = 40,
  parameter int MAP_ROWS     = 30,
  parameter int SCREEN_X_MAX = 639,
  parameter int SCREEN_Y_MAX = 479
) (
  input  logic      Clk,
  input  logic      Reset_n,
  collider_if.slave bus
);

  localparam int TILE_SHIFT = $clog2(TILE);
  localparam logic [4:0] ROW_LAST = 5'(MAP_ROWS - 1);
  localparam logic [5:0] COL_LAST = 6'(MAP_COLS - 1);

  logic [MAP_COLS-1:0] tile_map [MAP_ROWS];

  logic signed [31:0] x_cl, y_cl;
  logic signed [31:0] c0, c1, r0, r1;
  logic signed [31:0] c1_raw, r1_raw;
  logic signed [31:0] x_min_c, x_max_c, y_min_c, y_max_c;

  // Clamp the position onto the playfield and derive the spanned tile ranges.
  always_comb begin
    x_cl = bus.player_X_Pos;
    if (bus.player_X_Pos < 0)
      x_cl = 0;
    else if (bus.player_X_Pos > SCREEN_X_MAX)
      x_cl = SCREEN_X_MAX;

    y_cl = bus.player_Y_Pos;
    if (bus.player_Y_Pos < 0)
      y_cl = 0;
    else if (bus.player_Y_Pos > SCREEN_Y_MAX)
      y_cl = SCREEN_Y_MAX;

    c0     = x_cl >>> TILE_SHIFT;
    c1_raw = (x_cl + PLAYER_W - 1) >>> TILE_SHIFT;
    c1     = (c1_raw > MAP_COLS - 1) ? MAP_COLS - 1 : c1_raw;

    r0     = y_cl >>> TILE_SHIFT;
    r1_raw = (y_cl + PLAYER_H - 1) >>> TILE_SHIFT;
    r1     = (r1_raw > MAP_ROWS - 1) ? MAP_ROWS - 1 : r1_raw;
  end

  // Priority search over every solid tile: horizontal limits look only at
  // the spanned rows, vertical limits only at the spanned columns.
  always_comb begin
    x_min_c = 0;
    x_max_c = SCREEN_X_MAX;
    y_min_c = 0;
    y_max_c = SCREEN_Y_MAX;
    for (int r = 0; r < MAP_ROWS; r++) begin
      for (int c = 0; c < MAP_COLS; c++) begin
        if (tile_map[r][c]) begin
          if (r >= r0 && r <= r1) begin
            if ((c * TILE + TILE - 1 < x_cl) && (c * TILE + TILE > x_min_c))
              x_min_c = c * TILE + TILE;
            if ((c * TILE > x_cl + PLAYER_W - 1) && (c * TILE < x_max_c))
              x_max_c = c * TILE;
          end
          if (c >= c0 && c <= c1) begin
            if ((r * TILE + TILE - 1 < y_cl) && (r * TILE + TILE > y_min_c))
              y_min_c = r * TILE + TILE;
            if ((r * TILE > y_cl + PLAYER_H - 1) && (r * TILE < y_max_c))
              y_max_c = r * TILE;
          end
        end
      end
    end
  end

  // Tile map storage; reset restores the default level with a solid floor row.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < MAP_ROWS; r++)
        tile_map[r] <= (r == MAP_ROWS - 1) ? '1 : '0;
    end else if (bus.map_we && bus.map_row <= ROW_LAST && bus.map_col <= COL_LAST) begin
      tile_map[bus.map_row][bus.map_col] <= bus.map_solid;
    end
  end

  // Register the limits; this edge's result uses the map as it was before it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.player_X_Min <= 0;
      bus.player_X_Max <= SCREEN_X_MAX;
      bus.player_Y_Min <= 0;
      bus.player_Y_Max <= SCREEN_Y_MAX;
    end else begin
      bus.player_X_Min <= x_min_c;
      bus.player_X_Max <= x_max_c;
      bus.player_Y_Min <= y_min_c;
      bus.player_Y_Max <= y_max_c;
    end
  end

endmodule

// File: tb/tb_collider.sv
// Directed bench for collider: hand-computed limits for a sequence of map
// edits and player positions, including reset, clamping and same-edge writes.
module tb_collider;

  logic Clk;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  collider_if bus ();

  collider dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    bus.player_X_Pos = x;
    bus.player_Y_Pos = y;
  endtask

  // Arm a single map write to be taken on the next edge.
  task automatic apply_stimulus(input int row, input int col, input logic solid);
    bus.map_we    = 1'b1;
    bus.map_row   = 5'(row);
    bus.map_col   = 6'(col);
    bus.map_solid = solid;
  endtask

  // Perform a write, then one more edge so the new map reaches the outputs.
  task automatic write_tile(input int row, input int col, input logic solid);
    apply_stimulus(row, col, solid);
    tick();
    bus.map_we = 1'b0;
    tick();
  endtask

  task automatic check_output(input string tag, input int xmin, input int xmax,
                              input int ymin, input int ymax);
    checks++;
    assert (bus.player_X_Min === xmin) else begin
      errors++;
      $error("[TB] FAIL %s X_Min: got %0d expected %0d", tag, bus.player_X_Min, xmin);
    end
    checks++;
    assert (bus.player_X_Max === xmax) else begin
      errors++;
      $error("[TB] FAIL %s X_Max: got %0d expected %0d", tag, bus.player_X_Max, xmax);
    end
    checks++;
    assert (bus.player_Y_Min === ymin) else begin
      errors++;
      $error("[TB] FAIL %s Y_Min: got %0d expected %0d", tag, bus.player_Y_Min, ymin);
    end
    checks++;
    assert (bus.player_Y_Max === ymax) else begin
      errors++;
      $error("[TB] FAIL %s Y_Max: got %0d expected %0d", tag, bus.player_Y_Max, ymax);
    end
  endtask

  // Reset pulse released away from the active edge.
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #3;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n       = 1'b0;
    bus.map_we    = 1'b0;
    bus.map_row   = '0;
    bus.map_col   = '0;
    bus.map_solid = 1'b0;
    set_pos(32, 416);

    $display("[TB] reset and default floor");
    #22;
    check_output("in_reset", 0, 639, 0, 479);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check_output("post_reset", 0, 639, 0, 464);

    $display("[TB] wall to the right");
    set_pos(100, 400);
    apply_stimulus(26, 10, 1'b1);
    tick();
    bus.map_we = 1'b0;
    check_output("wall_r_old_map", 0, 639, 0, 464);
    tick();
    check_output("wall_r", 0, 160, 0, 464);

    $display("[TB] wall to the left and its boundary");
    write_tile(26, 3, 1'b1);
    check_output("wall_l", 64, 160, 0, 464);
    set_pos(64, 400);
    tick();
    check_output("wall_l_abut", 64, 160, 0, 464);
    set_pos(63, 400);
    tick();
    check_output("wall_l_overlap", 0, 160, 0, 464);

    $display("[TB] ceiling above");
    set_pos(100, 400);
    write_tile(20, 7, 1'b1);
    check_output("ceiling", 64, 160, 336, 464);

    $display("[TB] out-of-range writes ignored");
    write_tile(30, 5, 1'b1);
    write_tile(26, 40, 1'b1);
    check_output("oor_write", 64, 160, 336, 464);

    $display("[TB] asynchronous reset mid-run");
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_output("async_reset", 0, 639, 0, 479);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check_output("map_restored", 0, 639, 0, 464);

    $display("[TB] tile outside spanned rows and floor clearing");
    write_tile(10, 10, 1'b1);
    check_output("outside_rows", 0, 639, 0, 464);
    write_tile(29, 7, 1'b0);
    check_output("clear_29_7", 0, 639, 0, 464);
    write_tile(29, 6, 1'b0);
    write_tile(29, 8, 1'b0);
    check_output("floor_gone", 0, 639, 0, 479);

    $display("[TB] clamping");
    do_reset();
    set_pos(-5, -5);
    tick();
    check_output("negative_pos", 0, 639, 0, 464);
    set_pos(700, 500);
    tick();
    check_output("far_corner", 624, 639, 0, 479);

    $display("[TB] write and move on the same edge");
    set_pos(200, 100);
    apply_stimulus(8, 16, 1'b1);
    tick();
    bus.map_we = 1'b0;
    check_output("same_edge_old", 0, 639, 0, 464);
    tick();
    check_output("same_edge_new", 0, 256, 0, 464);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
